// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory loader.
package mips_pkg;

    localparam int WORD_SIZE = 32;
    localparam int BYTES_PER_WORD = WORD_SIZE / 8;
    localparam logic [WORD_SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: shifts UART bytes into a word, first byte ending up in the
// most significant lane. word_valid_o is combinational and coincides with
// the byte that completes the word, so word_o already includes that byte.
module byte_packer
    import mips_pkg::*;
#(
    parameter int SIZE = WORD_SIZE
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            clear_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_i,
    output logic [SIZE-1:0] word_o,
    output logic            word_valid_o
);

    localparam int BYTES = SIZE / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  shift_q, shift_d;

    // Next shift value and byte position; word completes on the last lane.
    always_comb begin
        shift_d      = (shift_q << 8) | SIZE'(byte_i);
        cnt_d        = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        word_o       = shift_d;
        word_valid_o = byte_valid_i && (cnt_q == LAST);
    end

    // Byte counter and shift register; clear_i realigns at the start of a load.
    always_ff @(posedge i_clk) begin
        if (i_rst || clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs debugger UART bytes into instruction words and
// writes them sequentially into instruction memory, stalling the pipeline
// while loading and issuing a one-cycle program reset after a good load.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a running XOR of every program byte (halt word included)
//   is compared against one extra byte received after the halt word.
//
// state | meaning
// IDLE  | waiting for i_start, bytes ignored
// RECV  | collecting bytes of the current word
// WRITE | write strobe active; decide halt / overflow / continue
// CHECK | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | one-cycle completion, o_done and optionally o_prog_reset high
module instr_mem_loader
    import mips_pkg::*;
#(
    parameter int              SIZE       = WORD_SIZE,
    parameter int              MEM_SIZE   = 64,
    parameter int              ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter logic [SIZE-1:0] HALT_WORD  = mips_pkg::HALT_WORD
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_rx_done,
    input  logic [7:0]            i_rx_data,
    output logic                  o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [SIZE-1:0]       o_write_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_prog_reset,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    loader_state_t state_q;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SIZE-1:0]       data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  prst_q;
    logic                  error_q;
    logic [ADDR_WIDTH:0]   word_count_q;

    logic                  pk_clear;
    logic                  pk_accept;
    logic [SIZE-1:0]       pk_word;
    logic                  pk_word_valid;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif

    // Bytes are taken while collecting and also during the write cycle, so a
    // back-to-back byte right after the 4th one becomes byte 0 of the next word.
    always_comb begin
        pk_clear  = (state_q == IDLE) && i_start;
        pk_accept = i_rx_done && ((state_q == RECV) || (state_q == WRITE));
    end

    byte_packer #(
        .SIZE (SIZE)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_accept),
        .byte_i       (i_rx_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    // Loader FSM with registered outputs, word counter and write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prst_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            prst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q      <= RECV;
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                        word_count_q <= '0;
                    end
                end
                RECV: begin
                    if (pk_word_valid) begin
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                        addr_q  <= word_count_q[ADDR_WIDTH-1:0];
                        data_q  <= pk_word;
                    end
                end
                WRITE: begin
                    word_count_q <= word_count_q + CNT_ONE;
                    if (data_q == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= CHECK;
`else
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        prst_q  <= 1'b1;
`endif
                    end else if (addr_q == LAST_ADDR) begin
                        // Memory full without a halt word: last slot is kept, load fails.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= RECV;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (i_rx_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (i_rx_data == xor_q) begin
                            prst_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every program byte the packer takes.
    always_ff @(posedge i_clk) begin
        if (i_rst || pk_clear) begin
            xor_q <= 8'h00;
        end else if (pk_accept) begin
            xor_q <= xor_q ^ i_rx_data;
        end
    end
`endif

    assign o_inst_write_enable = we_q;
    assign o_write_addr        = addr_q;
    assign o_write_data        = data_q;
    assign o_busy              = busy_q;
    assign o_done              = done_q;
    assign o_prog_reset        = prst_q;
    assign o_error             = error_q;
    assign o_word_count        = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: one default instance (MEM_SIZE=64) and one
// small instance (MEM_SIZE=4) for the overflow case. Expected writes are
// queued as stimulus is driven and popped by the write monitor.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic        a_we, a_busy, a_done, a_prst, a_err;
    logic [5:0]  a_addr;
    logic [31:0] a_data;
    logic [6:0]  a_cnt;

    logic        b_we, b_busy, b_done, b_prst, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_data;
    logic [2:0]  b_cnt;

    instr_mem_loader dut_a (
        .i_clk               (clk),
        .i_rst               (rst_a),
        .i_start             (start_a),
        .i_rx_done           (rx_done),
        .i_rx_data           (rx_data),
        .o_inst_write_enable (a_we),
        .o_write_addr        (a_addr),
        .o_write_data        (a_data),
        .o_busy              (a_busy),
        .o_done              (a_done),
        .o_prog_reset        (a_prst),
        .o_error             (a_err),
        .o_word_count        (a_cnt)
    );

    instr_mem_loader #(.MEM_SIZE(4)) dut_b (
        .i_clk               (clk),
        .i_rst               (rst_b),
        .i_start             (start_b),
        .i_rx_done           (rx_done),
        .i_rx_data           (rx_data),
        .o_inst_write_enable (b_we),
        .o_write_addr        (b_addr),
        .o_write_data        (b_data),
        .o_busy              (b_busy),
        .o_done              (b_done),
        .o_prog_reset        (b_prst),
        .o_error             (b_err),
        .o_word_count        (b_cnt)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  we_edge_q[$];
    int  checks = 0, failures = 0;
    int  cyc = 0;
    int  a_done_cnt = 0, a_prst_cnt = 0, a_wr_cnt = 0;
    int  b_done_cnt = 0, b_prst_cnt = 0;
    logic [7:0] tb_xor = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard and pulse counters.
    always @(negedge clk) begin
        wr_t e;
        if (a_we) begin
            a_wr_cnt++;
            we_edge_q.push_back(cyc);
            check("write_expected_a", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr_a", 64'(a_addr), 64'(e.addr));
                check("wr_data_a", 64'(a_data), 64'(e.data));
            end
        end
        if (b_we) begin
            check("write_expected_b", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr_b", 64'(b_addr), 64'(e.addr));
                check("wr_data_b", 64'(b_data), 64'(e.data));
            end
        end
        if (a_done) a_done_cnt++;
        if (a_prst) a_prst_cnt++;
        if (b_done) b_done_cnt++;
        if (b_prst) b_prst_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        tb_xor  = tb_xor ^ b;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_word(input int unsigned addr, input logic [31:0] w);
        exp_q.push_back('{addr: addr, data: w});
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic send_halt(input int unsigned addr);
        logic [7:0] cs;
        send_word(addr, 32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
        cs = tb_xor;
        send_byte(cs);
`else
        cs = 8'h00;
`endif
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1;
        start_a = 1'b1;
        tb_xor  = 8'h00;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    initial begin
        int d0, p0, w0;
        int tick_edge;
        logic [7:0] burst [8];

        // Reset state
        settle(3);
        rst_a = 1'b0;
        @(negedge clk);
        check("reset_outputs", {a_we, a_addr, a_data, a_busy, a_done, a_prst, a_err, a_cnt}, 64'd0);

        // 1: basic program
        d0 = a_done_cnt; p0 = a_prst_cnt;
        pulse_start_a();
        @(negedge clk);
        check("busy_after_start", 64'(a_busy), 64'd1);
        send_word(0, 32'h2008_0005);
        send_halt(1);
        settle(5);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t1_word_count", 64'(a_cnt), 64'd2);
        check("t1_done_pulses", 64'(a_done_cnt - d0), 64'd1);
        check("t1_prst_pulses", 64'(a_prst_cnt - p0), 64'd1);
        check("t1_error", 64'(a_err), 64'd0);
        check("t1_busy_low", 64'(a_busy), 64'd0);
        check("t1_addr_hold", 64'(a_addr), 64'd1);
        check("t1_data_hold", 64'(a_data), 64'hFFFF_FFFF);

        // 2: write latency and byte taken during the write cycle
        d0 = a_done_cnt; p0 = a_prst_cnt;
        pulse_start_a();
        we_edge_q.delete();
        burst = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back('{addr: 0, data: 32'hDEAD_BEEF});
        exp_q.push_back('{addr: 1, data: 32'h1122_3344});
        tick_edge = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx_data = burst[i];
            rx_done = 1'b1;
            tb_xor  = tb_xor ^ burst[i];
            if (i == 3) begin
                @(negedge clk);
                check("t2_we_not_early", 64'(a_we), 64'd0);
            end
            @(posedge clk); #1;
            if (i == 3) tick_edge = cyc;
        end
        rx_done = 1'b0;
        send_halt(2);
        settle(5);
        check("t2_we_edges", 64'(we_edge_q.size()), 64'd3);
        if (we_edge_q.size() >= 2) begin
            check("t2_latency_w0", 64'(we_edge_q[0]), 64'(tick_edge));
            check("t2_latency_w1", 64'(we_edge_q[1]), 64'(tick_edge + 4));
        end
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t2_word_count", 64'(a_cnt), 64'd3);
        check("t2_prst_pulses", 64'(a_prst_cnt - p0), 64'd1);
        check("t2_done_pulses", 64'(a_done_cnt - d0), 64'd1);

        // 3: overflow on the MEM_SIZE=4 instance
        rst_b = 1'b0;
        settle(2);
        d0 = b_done_cnt; p0 = b_prst_cnt;
        @(posedge clk); #1; start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        for (int i = 0; i < 4; i++) send_word(i, 32'h0102_0300 + 32'(i));
        settle(5);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t3_error", 64'(b_err), 64'd1);
        check("t3_done_pulses", 64'(b_done_cnt - d0), 64'd1);
        check("t3_prst_pulses", 64'(b_prst_cnt - p0), 64'd0);
        check("t3_word_count", 64'(b_cnt), 64'd4);
        check("t3_busy_low", 64'(b_busy), 64'd0);
        rst_b = 1'b1;

        // 4: reset mid-load, then a fresh load
        d0 = a_done_cnt; p0 = a_prst_cnt; w0 = a_wr_cnt;
        pulse_start_a();
        send_word(0, 32'hAABB_CCDD);
        send_byte(8'h55);
        send_byte(8'h66);
        @(posedge clk); #1; rst_a = 1'b1;
        @(posedge clk); #1; rst_a = 1'b0;
        @(negedge clk);
        check("t4_outputs_zero", {a_we, a_addr, a_data, a_busy, a_done, a_prst, a_err, a_cnt}, 64'd0);
        settle(4);
        check("t4_one_write", 64'(a_wr_cnt - w0), 64'd1);
        check("t4_no_done", 64'(a_done_cnt - d0), 64'd0);
        check("t4_no_prst", 64'(a_prst_cnt - p0), 64'd0);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        pulse_start_a();
        send_word(0, 32'h1234_5678);
        send_halt(1);
        settle(5);
        check("t4_reload_count", 64'(a_cnt), 64'd2);
        check("t4_reload_prst", 64'(a_prst_cnt - p0), 64'd1);

        // 5: idle ticks ignored, stray start mid-load ignored
        w0 = a_wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i));
        settle(3);
        check("t5_idle_no_write", 64'(a_wr_cnt - w0), 64'd0);
        check("t5_idle_not_busy", 64'(a_busy), 64'd0);
        d0 = a_done_cnt; p0 = a_prst_cnt;
        pulse_start_a();
        exp_q.push_back('{addr: 0, data: 32'hA1A2_A3A4});
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        send_byte(8'hA3);
        send_byte(8'hA4);
        send_halt(1);
        settle(5);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t5_word_count", 64'(a_cnt), 64'd2);
        check("t5_done_pulses", 64'(a_done_cnt - d0), 64'd1);
        check("t5_prst_pulses", 64'(a_prst_cnt - p0), 64'd1);
        check("t5_error", 64'(a_err), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum good and bad
        p0 = a_prst_cnt; d0 = a_done_cnt;
        pulse_start_a();
        send_word(0, 32'h0000_0000);
        send_word(1, 32'hFFFF_FFFF);
        send_byte(8'h00);
        settle(5);
        check("t6_good_prst", 64'(a_prst_cnt - p0), 64'd1);
        check("t6_good_error", 64'(a_err), 64'd0);
        p0 = a_prst_cnt; d0 = a_done_cnt;
        pulse_start_a();
        send_word(0, 32'h0000_0000);
        send_word(1, 32'hFFFF_FFFF);
        send_byte(8'h01);
        settle(5);
        check("t6_bad_error", 64'(a_err), 64'd1);
        check("t6_bad_done", 64'(a_done_cnt - d0), 64'd1);
        check("t6_bad_prst", 64'(a_prst_cnt - p0), 64'd0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
